vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between two users: display pixel fetch (fixed top priority) and a pixel writer (valid/ready).
- Holds the RAM as two banks (front/back) and swaps them only at vertical-blank start, giving tear-free double buffering.
- Sits between the 640x480 timing core (fetch strobe, vblank pulse), the pixel generator and the RAM.

Parameters:
- AW, 19, per-bank pixel address width (640*480 = 307200 fits in 2^19).
- DW, 12, pixel data width (RGB444).

Ports:
- i_VGA_CLOCK  in  1  pixel clock; all logic on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_fetch_en  in  1  display read request this cycle (one cycle ahead of DE).
- i_fetch_addr  in  AW  display pixel address within the front bank.
- i_vblank_start  in  1  one-cycle pulse at the first vblank line.
- i_wr_valid  in  1  writer request.
- i_wr_addr  in  AW  writer pixel address within the back bank.
- i_wr_data  in  DW  writer pixel data.
- o_wr_ready  out  1  writer handshake accepted when i_wr_valid && o_wr_ready.
- i_swap_req  in  1  one-cycle pulse: back buffer complete, request swap.
- o_swap_ack  out  1  one-cycle pulse when the swap takes effect.
- o_fb_sel  out  1  current front-bank index.
- o_mem_en  out  1  RAM access enable.
- o_mem_we  out  1  RAM write enable.
- o_mem_addr  out  AW+1  {bank, address}.
- o_mem_wdata  out  DW  RAM write data.
- i_mem_rdata  in  DW  RAM read data, 1-cycle latency after o_mem_en && !o_mem_we.
- o_pix_valid  out  1  o_pix_data is valid.
- o_pix_data  out  DW  fetched pixel.

Behaviour:
- Reset: o_fb_sel=0, o_swap_ack=0, o_pix_valid=0, o_pix_data=0, hold register empty, FSM=IDLE. Reset is synchronous and overrides everything, including a write or swap in progress.
- RAM outputs are combinational from the current-cycle grant.
  - o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata are zero when no access is issued.
- Hold register: one entry (addr, data, valid).
  - A write is accepted into the hold register on a handshake.
  - o_wr_ready = !hold_valid && FSM==IDLE.
- Grant priority each cycle:
  - If i_fetch_en: issue read at {o_fb_sel, i_fetch_addr}. Fetch is never stalled.
  - Else if hold_valid: issue write at {~o_fb_sel, hold_addr} with hold_data, and clear hold_valid that same edge.
  - A handshake and a drain in the same cycle are impossible, because ready requires the hold register to be empty.
- Read return: o_pix_valid and o_pix_data register i_fetch_en and i_mem_rdata with 1 cycle latency.
  - o_pix_valid = i_fetch_en delayed 1 cycle.
  - o_pix_data = i_mem_rdata sampled while o_pix_valid is high; otherwise it holds its last value.
- Swap FSM, states IDLE, DRAIN, ARMED:
  - IDLE: on i_swap_req go to DRAIN.
  - DRAIN: o_wr_ready=0. When hold_valid==0, go to ARMED.
  - ARMED: on i_vblank_start, toggle o_fb_sel, pulse o_swap_ack for 1 cycle, go to IDLE.
  - i_swap_req in DRAIN or ARMED is ignored; no queuing.
  - i_vblank_start in IDLE or DRAIN does nothing. A swap missed during DRAIN waits for the next frame's pulse.
  - i_swap_req coincident with i_vblank_start in IDLE: go to DRAIN; the swap occurs at a later vblank, never in the same cycle.
  - Transition to IDLE and the o_fb_sel toggle land on the same edge. Writes accepted afterwards target the new back bank.
- Address widths: no wrap or range check. Addresses ≥ 307200 pass through unchanged.

Test Plan:
- Reset, then idle. Expect o_fb_sel=0, o_wr_ready=1, o_mem_en=0, o_pix_valid=0.
- Write addr 0x00010, data 0xABC, with i_fetch_en=0.
  - Expect handshake at cycle 0.
  - Expect o_mem_we=1, o_mem_addr=0x80010, o_mem_wdata=0xABC at cycle 1.
  - Expect o_wr_ready back to 1 at cycle 2.
- Fetch collision: i_fetch_en=1 for 10 cycles (addresses 0..9) while the writer offers 0x555 at addr 5.
  - Expect 10 reads to bank 0 and o_wr_ready=0 from cycle 1.
  - Expect the write issued to 0x80005 on the first cycle with i_fetch_en=0.
  - Expect o_pix_valid for 10 cycles starting 1 cycle after the first fetch, with o_pix_data tracking the RAM model.
- Swap: i_swap_req pulse while idle, then i_vblank_start 50 cycles later.
  - Expect o_wr_ready=0 during ARMED.
  - Expect o_swap_ack pulse and o_fb_sel=1 one cycle after the vblank pulse.
  - Expect subsequent writes at bank 0 (o_mem_addr MSB=0).
- Missed vblank: hold register full under continuous fetch, i_swap_req pulsed, i_vblank_start arriving while in DRAIN.
  - Expect no swap on that pulse.
  - Expect the swap on the following i_vblank_start.
- Simultaneous events and reset:
  - i_swap_req and i_vblank_start in the same cycle: expect no ack that cycle.
  - Assert i_rst_n=0 while in ARMED: expect FSM=IDLE, o_fb_sel=0, hold register emptied, no ack.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// Pixel-writer handshake and single-port framebuffer RAM bus, seen from the arbiter.
// master = arbiter side (accepts writes, drives the RAM); slave = writer + RAM side.
interface vga_fb_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 12
) ();
  logic          i_wr_valid;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          o_wr_ready;

  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW:0]   o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;

  modport master (
    input  i_wr_valid, i_wr_addr, i_wr_data,
    output o_wr_ready,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  modport slave (
    output i_wr_valid, i_wr_addr, i_wr_data,
    input  o_wr_ready,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Double-buffered framebuffer arbiter: display fetch has absolute priority over a
// one-entry write hold register; front/back banks swap only at vblank start.
module vga_fb_arbiter #(
  parameter int AW = 19,
  parameter int DW = 12
) (
  input  logic              i_VGA_CLOCK,
  input  logic              i_rst_n,
  input  logic              i_fetch_en,
  input  logic [AW-1:0]     i_fetch_addr,
  input  logic              i_vblank_start,
  input  logic              i_swap_req,
  output logic              o_swap_ack,
  output logic              o_fb_sel,
  output logic              o_pix_valid,
  output logic [DW-1:0]     o_pix_data,
  vga_fb_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          fb_sel_q, fb_sel_d;
  logic          swap_ack_q, swap_ack_d;
  logic          hold_valid_q, hold_valid_d;
  logic [AW-1:0] hold_addr_q, hold_addr_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic          pix_valid_q, pix_valid_d;
  logic [DW-1:0] pix_data_q, pix_data_d;

  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] pix_data;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d      = state_q;
    fb_sel_d     = fb_sel_q;
    swap_ack_d   = 1'b0;
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    wr_ready = !hold_valid_q && (state_q == IDLE);

    if (i_fetch_en) begin
      mem_en   = 1'b1;
      mem_addr = {fb_sel_q, i_fetch_addr};
    end else if (hold_valid_q) begin
      mem_en       = 1'b1;
      mem_we       = 1'b1;
      mem_addr     = {~fb_sel_q, hold_addr_q};
      mem_wdata    = hold_data_q;
      hold_valid_d = 1'b0;
    end

    // Cannot collide with the drain above: ready implies the hold register is empty.
    if (bus.i_wr_valid && wr_ready) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = bus.i_wr_addr;
      hold_data_d  = bus.i_wr_data;
    end

    unique case (state_q)
      IDLE:  if (i_swap_req) state_d = DRAIN;
      DRAIN: if (!hold_valid_q) state_d = ARMED;
      ARMED: if (i_vblank_start) begin
        state_d    = IDLE;
        fb_sel_d   = ~fb_sel_q;
        swap_ack_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // RAM data is valid in the cycle after the read; latch it so it holds afterwards.
    pix_valid_d = i_fetch_en;
    pix_data    = pix_valid_q ? bus.i_mem_rdata : pix_data_q;
    pix_data_d  = pix_data;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_VGA_CLOCK) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      fb_sel_q     <= 1'b0;
      swap_ack_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      fb_sel_q     <= fb_sel_d;
      swap_ack_q   <= swap_ack_d;
      hold_valid_q <= hold_valid_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
    end
  end

  // NOTE: hold payload needs no reset; it is only ever read while hold_valid_q is set.
  always_ff @(posedge i_VGA_CLOCK) begin
    hold_addr_q <= hold_addr_d;
    hold_data_q <= hold_data_d;
  end

  assign bus.o_wr_ready  = wr_ready;
  assign bus.o_mem_en    = mem_en;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;

  assign o_swap_ack  = swap_ack_q;
  assign o_fb_sel    = fb_sel_q;
  assign o_pix_valid = pix_valid_q;
  assign o_pix_data  = pix_data;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: behavioural RAM with a known read pattern,
// linear stimulus, hand-computed expectations checked one cycle at a time.
module tb_vga_fb_arbiter;
  localparam int AW = 19;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_en;
  logic [AW-1:0] fetch_addr;
  logic          vblank_start;
  logic          swap_req;
  logic          swap_ack;
  logic          fb_sel;
  logic          pix_valid;
  logic [DW-1:0] pix_data;

  int checks = 0;
  int errors = 0;

  vga_fb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  vga_fb_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_VGA_CLOCK    (clk),
    .i_rst_n        (rst_n),
    .i_fetch_en     (fetch_en),
    .i_fetch_addr   (fetch_addr),
    .i_vblank_start (vblank_start),
    .i_swap_req     (swap_req),
    .o_swap_ack     (swap_ack),
    .o_fb_sel       (fb_sel),
    .o_pix_valid    (pix_valid),
    .o_pix_data     (pix_data),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Unwritten locations read back a fixed function of their address.
  function automatic logic [DW-1:0] pat(input logic [AW:0] a);
    return a[11:0] ^ 12'hA5A ^ {3'b000, a[19], 8'h00};
  endfunction

  logic [DW-1:0] ram [logic [AW:0]];

  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_we) ram[bus.o_mem_addr] = bus.o_mem_wdata;
      else if (ram.exists(bus.o_mem_addr)) bus.i_mem_rdata <= ram[bus.o_mem_addr];
      else bus.i_mem_rdata <= pat(bus.o_mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; fetch_addr = '0; vblank_start = 1'b0; swap_req = 1'b0;
    bus.i_wr_valid = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0; bus.i_mem_rdata = '0;

    // Reset then idle
    repeat (3) tick();
    rst_n = 1'b1; settle();
    check("rst_fb_sel", fb_sel, 0);
    check("rst_wr_ready", bus.o_wr_ready, 1);
    check("rst_mem_en", bus.o_mem_en, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_swap_ack", swap_ack, 0);

    // Single write, no fetch: handshake, drain to back bank 1, ready again
    tick(); bus.i_wr_valid = 1'b1; bus.i_wr_addr = 19'h00010; bus.i_wr_data = 12'hABC; settle();
    check("wr_hs_ready", bus.o_wr_ready, 1);
    check("wr_hs_mem_en", bus.o_mem_en, 0);
    tick(); bus.i_wr_valid = 1'b0; settle();
    check("wr_drain_en", bus.o_mem_en, 1);
    check("wr_drain_we", bus.o_mem_we, 1);
    check("wr_drain_addr", bus.o_mem_addr, 20'h80010);
    check("wr_drain_data", bus.o_mem_wdata, 12'hABC);
    check("wr_drain_ready", bus.o_wr_ready, 0);
    tick(); settle();
    check("wr_ready_back", bus.o_wr_ready, 1);
    check("wr_idle_en", bus.o_mem_en, 0);

    // Fetch burst 0..9 colliding with a write offered at cycle 0
    for (int i = 0; i < 10; i++) begin
      tick();
      fetch_en = 1'b1; fetch_addr = AW'(i);
      bus.i_wr_valid = (i == 0); bus.i_wr_addr = 19'h00005; bus.i_wr_data = 12'h555;
      settle();
      check("col_ready", bus.o_wr_ready, (i == 0) ? 1 : 0);
      check("col_rd_en", bus.o_mem_en, 1);
      check("col_rd_we", bus.o_mem_we, 0);
      check("col_rd_addr", bus.o_mem_addr, 32'(i));
      check("col_pix_valid", pix_valid, (i > 0) ? 1 : 0);
      if (i > 0) check("col_pix_data", pix_data, pat(20'(i - 1)));
    end
    tick(); fetch_en = 1'b0; bus.i_wr_valid = 1'b0; settle();
    check("col_wr_we", bus.o_mem_we, 1);
    check("col_wr_addr", bus.o_mem_addr, 20'h80005);
    check("col_wr_data", bus.o_mem_wdata, 12'h555);
    check("col_last_pix_valid", pix_valid, 1);
    check("col_last_pix_data", pix_data, pat(20'h00009));
    tick(); settle();
    check("col_pix_valid_off", pix_valid, 0);
    check("col_pix_data_hold", pix_data, pat(20'h00009));
    check("col_ready_back", bus.o_wr_ready, 1);

    // Swap: request while idle, vblank 50 cycles later
    tick(); swap_req = 1'b1; settle();
    check("sw_req_ready", bus.o_wr_ready, 1);
    for (int k = 1; k < 50; k++) begin
      tick(); swap_req = 1'b0; settle();
      check("sw_wait_ready", bus.o_wr_ready, 0);
      check("sw_wait_ack", swap_ack, 0);
    end
    tick(); vblank_start = 1'b1; settle();
    check("sw_vb_ack", swap_ack, 0);
    check("sw_vb_fb_sel", fb_sel, 0);
    tick(); vblank_start = 1'b0; settle();
    check("sw_ack", swap_ack, 1);
    check("sw_fb_sel", fb_sel, 1);
    check("sw_ready", bus.o_wr_ready, 1);
    tick(); settle();
    check("sw_ack_pulse", swap_ack, 0);
    check("sw_fb_sel_hold", fb_sel, 1);
    tick(); bus.i_wr_valid = 1'b1; bus.i_wr_addr = 19'h00020; bus.i_wr_data = 12'h123; settle();
    check("sw_wr_ready", bus.o_wr_ready, 1);
    tick(); bus.i_wr_valid = 1'b0; settle();
    check("sw_wr_we", bus.o_mem_we, 1);
    check("sw_wr_addr", bus.o_mem_addr, 20'h00020);
    tick(); fetch_en = 1'b1; fetch_addr = 19'h00003; settle();
    check("sw_rd_addr", bus.o_mem_addr, 20'h80003);
    tick(); fetch_en = 1'b0; settle();
    check("sw_rd_pix", pix_data, pat(20'h80003));

    // Missed vblank: hold full behind continuous fetch, vblank lands in DRAIN
    tick(); fetch_en = 1'b1; fetch_addr = 19'h00100;
    bus.i_wr_valid = 1'b1; bus.i_wr_addr = 19'h00030; bus.i_wr_data = 12'h777; settle();
    check("mv_hs_ready", bus.o_wr_ready, 1);
    check("mv_rd_addr", bus.o_mem_addr, 20'h80100);
    tick(); bus.i_wr_valid = 1'b0; swap_req = 1'b1; fetch_addr = 19'h00101; settle();
    check("mv_full_ready", bus.o_wr_ready, 0);
    check("mv_full_we", bus.o_mem_we, 0);
    tick(); swap_req = 1'b0; fetch_addr = 19'h00102; settle();
    check("mv_drain_ready", bus.o_wr_ready, 0);
    tick(); vblank_start = 1'b1; fetch_addr = 19'h00103; settle();
    check("mv_vb_ack", swap_ack, 0);
    tick(); vblank_start = 1'b0; fetch_en = 1'b0; settle();
    check("mv_no_ack", swap_ack, 0);
    check("mv_no_swap", fb_sel, 1);
    check("mv_wr_we", bus.o_mem_we, 1);
    check("mv_wr_addr", bus.o_mem_addr, 20'h00030);
    check("mv_wr_data", bus.o_mem_wdata, 12'h777);
    check("mv_pix_data", pix_data, pat(20'h80103));
    tick(); settle();
    check("mv_post_ready", bus.o_wr_ready, 0);
    check("mv_post_en", bus.o_mem_en, 0);
    repeat (6) tick();
    vblank_start = 1'b1; settle();
    check("mv_vb2_ack", swap_ack, 0);
    tick(); vblank_start = 1'b0; settle();
    check("mv_ack", swap_ack, 1);
    check("mv_fb_sel", fb_sel, 0);
    tick(); settle();
    check("mv_ack_pulse", swap_ack, 0);

    // Swap request coincident with vblank in IDLE: no same-cycle swap
    tick(); swap_req = 1'b1; vblank_start = 1'b1; settle();
    check("co_ack_now", swap_ack, 0);
    tick(); swap_req = 1'b0; vblank_start = 1'b0; settle();
    check("co_ack_next", swap_ack, 0);
    check("co_fb_sel", fb_sel, 0);
    check("co_drain_ready", bus.o_wr_ready, 0);
    tick(); settle();
    check("co_armed_ready", bus.o_wr_ready, 0);
    tick(); vblank_start = 1'b1; settle();
    tick(); vblank_start = 1'b0; settle();
    check("co_ack", swap_ack, 1);
    check("co_fb_sel_swapped", fb_sel, 1);

    // Reset with the hold register full behind a fetch
    tick(); fetch_en = 1'b1; fetch_addr = 19'h00000; swap_req = 1'b1;
    bus.i_wr_valid = 1'b1; bus.i_wr_addr = 19'h00040; bus.i_wr_data = 12'h009; settle();
    check("rh_hs_ready", bus.o_wr_ready, 1);
    tick(); bus.i_wr_valid = 1'b0; swap_req = 1'b0; settle();
    check("rh_full_ready", bus.o_wr_ready, 0);
    tick(); rst_n = 1'b0; settle();
    tick(); rst_n = 1'b1; fetch_en = 1'b0; settle();
    check("rh_no_drain", bus.o_mem_en, 0);
    check("rh_ready", bus.o_wr_ready, 1);
    check("rh_fb_sel", fb_sel, 0);
    check("rh_pix_valid", pix_valid, 0);
    check("rh_pix_data", pix_data, 0);

    // Reset while ARMED, with vblank during reset
    tick(); swap_req = 1'b1; settle();
    tick(); swap_req = 1'b0; settle();
    tick(); settle();
    check("ra_armed_ready", bus.o_wr_ready, 0);
    tick(); rst_n = 1'b0; vblank_start = 1'b1; settle();
    tick(); rst_n = 1'b1; vblank_start = 1'b0; settle();
    check("ra_ack", swap_ack, 0);
    check("ra_fb_sel", fb_sel, 0);
    check("ra_ready", bus.o_wr_ready, 1);
    tick(); vblank_start = 1'b1; settle();
    tick(); vblank_start = 1'b0; settle();
    check("ra_idle_vb_ack", swap_ack, 0);
    check("ra_idle_vb_fb_sel", fb_sel, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
